obuf_drain_ctrl: RTL and testbench
==================================

// Module: obuf_drain_ctrl
// PURPOSE
// Read-side drain engine for the output buffer banks. On start it reads
// num_rows consecutive addresses from all NUM_BANKS banks in lockstep, absorbs
// the fixed bank read latency, and serializes each row into DDR_BANDWIDTH-wide
// beats on a valid/ready stream toward the DDR write-back path.
// PARAMETERS
// NUM_BANKS       64   banks read in lockstep
// READ_WIDTH      32   bits returned per bank per read
// READ_ADDR_WIDTH 8    bank read address width
// READ_LATENCY_B  1    cycles from bs_read_req to bs_read_data valid (>=1)
// DDR_BANDWIDTH   512  output beat width; NUM_BANKS*READ_WIDTH % DDR_BANDWIDTH == 0
// FIFO_DEPTH      4    row FIFO entries (>= READ_LATENCY_B+2)
// PORTS
// clk           in   1                         clock
// reset         in   1                         asynchronous, active-low reset
// start         in   1                         1-cycle request, sampled in IDLE only
// base_addr     in   READ_ADDR_WIDTH           first bank address
// num_rows      in   READ_ADDR_WIDTH+1         rows to drain (0 allowed)
// busy          out  1                         high from accepted start until done
// done          out  1                         1-cycle pulse at completion
// bs_read_req   out  NUM_BANKS                 per-bank read enable (all bits equal)
// bs_read_addr  out  NUM_BANKS*READ_ADDR_WIDTH same address replicated per bank
// bs_read_data  in   NUM_BANKS*READ_WIDTH      bank n at [n*READ_WIDTH +: READ_WIDTH]
// m_data        out  DDR_BANDWIDTH             output beat
// m_valid       out  1                         beat valid
// m_ready       in   1                         downstream accept
// m_last        out  1                         final beat of final row
// BEHAVIOUR
// - Reset (async, active-low): all outputs 0, FSM=IDLE, FIFO empty, read-valid
//   shift pipe cleared; reset mid-drain discards in-flight bank data.
// - BEATS = NUM_BANKS*READ_WIDTH/DDR_BANDWIDTH. Row = concat of banks, bank 0 in
//   LSBs; beat k = row[k*DDR_BANDWIDTH +: DDR_BANDWIDTH], k=0 first.
// - FSM: IDLE -start-> ISSUE (num_rows>0) or DONE (num_rows==0, no beats);
//   ISSUE -last read issued-> DRAIN; DRAIN -FIFO empty & no in-flight & final
//   beat accepted-> DONE; DONE -> IDLE (done=1 this cycle, busy=0 next).
// - start while busy is ignored. base_addr/num_rows captured on accepted start.
// - Issue: in ISSUE, read row i at addr=(base_addr+i) mod 2^READ_ADDR_WIDTH when
//   fifo_count + inflight < FIFO_DEPTH; bs_read_req=0 otherwise.
// - A READ_LATENCY_B-deep valid pipe marks returning data; it is written to the
//   FIFO in the cycle bs_read_data is valid. Credit check guarantees no overflow.
// - Output: head row serialized; beat counter advances on m_valid&m_ready; FIFO
//   pops on acceptance of beat BEATS-1. m_data/m_valid/m_last held stable while
//   m_valid & !m_ready. Beats registered (m_valid one cycle after FIFO write).
// - Latency: start sampled cycle 0 -> first bs_read_req cycle 1 -> first m_valid
//   cycle 2+READ_LATENCY_B. With m_ready=1: one beat/cycle, no bubbles, total
//   beats = num_rows*BEATS.
// - m_last=1 only on beat BEATS-1 of row num_rows-1; done follows its acceptance.
// - Simultaneous FIFO push and pop in same cycle: count unchanged, both honoured.
// TESTING
// T1 base=0x10,rows=3,ready=1,bank n word=addr<<8|n -> 12 beats back-to-back,
//    beat0 of row0 = banks 0..15, m_last on beat 12, done 1 cycle later.
// T2 rows=0 -> no bs_read_req, no m_valid, done pulses cycle 1 after start.
// T3 base=0xFE,rows=4 -> addresses 0xFE,0xFF,0x00,0x01 issued in order.
// T4 m_ready random 30% -> data stable under stall, FIFO never overflows,
//    beat order/content matches model, bs_read_req stalls when credits exhausted.
// T5 start pulsed again mid-drain -> ignored; single done; beat count unchanged.
// T6 reset asserted during DRAIN with data in flight -> outputs 0 immediately,
//    next start drains cleanly with no stale beats.

Source files
------------

// File: rtl/obuf_drain_ctrl_if.sv
// obuf_drain_ctrl_if: control, bank-read and beat-stream signals of the obuf drain engine
interface obuf_drain_ctrl_if #(
  parameter int NUM_BANKS = 64,
  parameter int READ_WIDTH = 32,
  parameter int READ_ADDR_WIDTH = 8,
  parameter int DDR_BANDWIDTH = 512
);
  logic start;
  logic [READ_ADDR_WIDTH-1:0] base_addr;
  logic [READ_ADDR_WIDTH:0] num_rows;
  logic busy;
  logic done;
  logic [NUM_BANKS-1:0] bs_read_req;
  logic [NUM_BANKS*READ_ADDR_WIDTH-1:0] bs_read_addr;
  logic [NUM_BANKS*READ_WIDTH-1:0] bs_read_data;
  logic [DDR_BANDWIDTH-1:0] m_data;
  logic m_valid;
  logic m_ready;
  logic m_last;
  modport master (
    input start, base_addr, num_rows, bs_read_data, m_ready,
    output busy, done, bs_read_req, bs_read_addr, m_data, m_valid, m_last
  );
  modport slave (
    output start, base_addr, num_rows, bs_read_data, m_ready,
    input busy, done, bs_read_req, bs_read_addr, m_data, m_valid, m_last
  );
endinterface

// File: rtl/obuf_drain_ctrl.sv
// obuf_drain_ctrl: reads rows from all banks in lockstep and serializes them into DDR beats
module obuf_drain_ctrl #(
  parameter int NUM_BANKS = 64,
  parameter int READ_WIDTH = 32,
  parameter int READ_ADDR_WIDTH = 8,
  parameter int READ_LATENCY_B = 1,
  parameter int DDR_BANDWIDTH = 512,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  obuf_drain_ctrl_if.master bus
);
  localparam int AW = READ_ADDR_WIDTH;
  localparam int BEATS = NUM_BANKS * READ_WIDTH / DDR_BANDWIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic [AW-1:0] base_r, addr;
  logic [AW:0] rows_r, issue_cnt, pop_cnt;
  logic [READ_LATENCY_B-1:0] vpipe;
  logic [CW-1:0] count, inflight;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] beat;
  logic [BEATS-1:0][DDR_BANDWIDTH-1:0] mem [FIFO_DEPTH];
  logic req, push, pop, fire, last_beat, last_row;
  // rows already in the FIFO plus rows still in the bank pipe bound how far issue may run ahead
  assign req = state == ISSUE && ({1'b0, count} + {1'b0, inflight}) < (CW+1)'(FIFO_DEPTH);
  assign push = vpipe[READ_LATENCY_B-1];
  assign addr = base_r + issue_cnt[AW-1:0];
  assign fire = bus.m_valid && bus.m_ready;
  assign last_beat = beat == BW'(BEATS - 1);
  assign last_row = pop_cnt == rows_r - (AW+1)'(1);
  assign pop = fire && last_beat;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.bs_read_req = {NUM_BANKS{req}};
  assign bus.bs_read_addr = {NUM_BANKS{req ? addr : AW'(0)}};
  assign bus.m_valid = count != '0;
  assign bus.m_data = bus.m_valid ? mem[rd_ptr][beat] : '0;
  assign bus.m_last = bus.m_valid && last_beat && last_row;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = bus.start ? (bus.num_rows == '0 ? DONE : ISSUE) : IDLE;
      ISSUE: state_n = req && issue_cnt == rows_r - (AW+1)'(1) ? DRAIN : ISSUE;
      DRAIN: state_n = fire && bus.m_last ? DONE : DRAIN;
      DONE: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      base_r <= '0;
      rows_r <= '0;
      issue_cnt <= '0;
      pop_cnt <= '0;
      vpipe <= '0;
      count <= '0;
      inflight <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      beat <= '0;
    end else begin
      state <= state_n;
      vpipe <= (vpipe << 1) | READ_LATENCY_B'(req);
      inflight <= inflight + CW'(req) - CW'(push);
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
      if (pop) pop_cnt <= pop_cnt + (AW+1)'(1);
      if (fire) beat <= last_beat ? '0 : beat + BW'(1);
      if (req) issue_cnt <= issue_cnt + (AW+1)'(1);
      if (state == IDLE && bus.start) begin
        base_r <= bus.base_addr;
        rows_r <= bus.num_rows;
        issue_cnt <= '0;
        pop_cnt <= '0;
        beat <= '0;
      end
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= bus.bs_read_data;
endmodule

// File: tb/tb_obuf_drain_ctrl.sv
// tb_obuf_drain_ctrl: scoreboard bench; a bank model answers reads, a monitor checks beats against queued expectations
module tb_obuf_drain_ctrl;
  localparam int NB = 64, RW = 32, AW = 8, LAT = 1, DW = 512, FD = 4, BEATS = NB * RW / DW;
  typedef struct {logic [DW-1:0] data; logic last;} beat_t;
  logic clk = 0;
  logic reset = 0;
  beat_t beatq[$];
  logic [AW-1:0] addrq[$];
  int tests = 0, fails = 0, cyc = 0, done_cnt = 0, done_cyc = -1, s_cyc = 0;
  int first_v = -1, first_req = -1, last_fire = -1, nbeats = 0, req_cnt = 0, row_cnt = 0;
  bit rand_rdy = 0, stall_seen = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  obuf_drain_ctrl_if #(.NUM_BANKS(NB), .READ_WIDTH(RW), .READ_ADDR_WIDTH(AW), .DDR_BANDWIDTH(DW)) bus ();
  obuf_drain_ctrl #(.NUM_BANKS(NB), .READ_WIDTH(RW), .READ_ADDR_WIDTH(AW), .READ_LATENCY_B(LAT),
    .DDR_BANDWIDTH(DW), .FIFO_DEPTH(FD)) dut (.clk(clk), .reset(reset), .bus(bus));
  function automatic logic [NB*RW-1:0] row_of(input logic [AW-1:0] a);
    logic [NB*RW-1:0] r;
    r = '0;
    for (int n = 0; n < NB; n++) r[n*RW +: RW] = {16'h0, a, 8'(n)};
    return r;
  endfunction
  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // bank model: one-cycle read latency, garbage when not read
  always @(posedge clk) bus.bs_read_data <= bus.bs_read_req[0] ? row_of(bus.bs_read_addr[AW-1:0]) : {NB*RW{1'b1}};
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 bus.m_ready = rand_rdy ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end
  end
  always @(negedge clk) if (reset) begin
    if (bus.bs_read_req != '0) begin
      if (first_req < 0) first_req = cyc;
      chk("req_all_banks", &bus.bs_read_req, 1);
      chk("credit", (req_cnt - row_cnt) < FD, 1);
      req_cnt++;
      if (addrq.size() == 0) chk("unexpected_req", bus.bs_read_addr[AW-1:0], 'x);
      else chk("rd_addr", bus.bs_read_addr[AW-1:0], addrq.pop_front());
    end else if (bus.busy && addrq.size() > 0) stall_seen = 1;
    if (bus.m_valid) begin
      if (first_v < 0) first_v = cyc;
      if (beatq.size() == 0) chk("unexpected_beat", bus.m_data, 'x);
      else begin
        chk("beat_data", bus.m_data, beatq[0].data);
        chk("beat_last", bus.m_last, beatq[0].last);
        if (bus.m_ready) begin
          void'(beatq.pop_front());
          nbeats++;
          if (nbeats % BEATS == 0) row_cnt++;
          last_fire = cyc;
        end
      end
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end
  task automatic push_exp(input logic [AW-1:0] base, input int rows);
    for (int r = 0; r < rows; r++) begin
      logic [AW-1:0] a;
      logic [NB*RW-1:0] row;
      a = base + AW'(r);
      row = row_of(a);
      addrq.push_back(a);
      for (int k = 0; k < BEATS; k++) beatq.push_back('{row[k*DW +: DW], (k == BEATS - 1) && (r == rows - 1)});
    end
  endtask
  task automatic run(input logic [AW-1:0] base, input int rows, input int budget, input int restart);
    int d0;
    push_exp(base, rows);
    d0 = done_cnt;
    first_v = -1;
    first_req = -1;
    @(posedge clk);
    #1 bus.start = 1;
    bus.base_addr = base;
    bus.num_rows = (AW+1)'(rows);
    s_cyc = cyc;
    for (int i = 0; i < budget && done_cnt == d0; i++) begin
      @(posedge clk);
      #1 bus.start = i == restart;
      bus.base_addr = 8'h33;
      bus.num_rows = 9'd7;
    end
    bus.start = 0;
    repeat (4) @(posedge clk);
    #1 chk("done_count", done_cnt - d0, 1);
    chk("beats_left", beatq.size(), 0);
    chk("addrs_left", addrq.size(), 0);
  endtask
  initial begin
    int nb0;
    bus.start = 0;
    bus.base_addr = '0;
    bus.num_rows = '0;
    repeat (3) @(posedge clk);
    #1 chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_valid", bus.m_valid, 0);
    chk("rst_req", bus.bs_read_req, 0);
    chk("rst_last", bus.m_last, 0);
    reset = 1;
    // T1: back-to-back beats with timing checks
    run(8'h10, 3, 100, -1);
    chk("t1_first_req", first_req, s_cyc + 1);
    chk("t1_first_valid", first_v, s_cyc + 2 + LAT);
    chk("t1_no_bubbles", last_fire - first_v, 3 * BEATS - 1);
    chk("t1_done_after_last", done_cyc, last_fire + 1);
    // T2: zero rows
    run(8'h00, 0, 20, -1);
    chk("t2_done_cycle", done_cyc, s_cyc + 1);
    chk("t2_no_valid", first_v, -1);
    chk("t2_no_req", first_req, -1);
    // T3: address wrap
    run(8'hFE, 4, 200, -1);
    // T4: random backpressure, credit stalls
    rand_rdy = 1;
    stall_seen = 0;
    run(8'h80, 10, 2000, -1);
    rand_rdy = 0;
    chk("t4_issue_stalled", stall_seen, 1);
    // T5: second start while busy
    run(8'h50, 3, 200, 5);
    // T6: reset while draining with a row still in flight
    push_exp(8'h20, 3);
    nb0 = nbeats;
    @(posedge clk);
    #1 bus.start = 1;
    bus.base_addr = 8'h20;
    bus.num_rows = 9'd3;
    @(posedge clk);
    #1 bus.start = 0;
    for (int i = 0; i < 50 && nbeats == nb0; i++) @(posedge clk);
    #1 chk("t6_progress", nbeats > nb0, 1);
    reset = 0;
    #1 chk("t6_busy", bus.busy, 0);
    chk("t6_valid", bus.m_valid, 0);
    chk("t6_data", bus.m_data, 0);
    chk("t6_req", bus.bs_read_req, 0);
    chk("t6_done", bus.done, 0);
    beatq.delete();
    addrq.delete();
    nbeats = 0;
    req_cnt = 0;
    row_cnt = 0;
    @(posedge clk);
    #1 reset = 1;
    run(8'h40, 2, 100, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end
endmodule
